// File: rtl/seq_ctrl.sv
// seq_ctrl -- small instruction sequencer driving an external ALU and a send port.
//
// Holds a 4 x ALU_W register file. Each accepted instruction is either issued to
// the ALU (push / add / mult) and its result written back, or sent out on the
// send port (send). A WAIT state absorbs ALU latency and aborts after TIMEOUT
// extra cycles, raising a sticky error flag.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_inst, i_inst_valid      instruction offer
//   o_inst_ready              instruction accepted this cycle (IDLE and not in reset)
//   o_alu_a/b/op/const        ALU operands, held from ISSUE through the last WAIT cycle
//   o_alu_valid               one-cycle issue strobe
//   i_alu_data, i_alu_valid   ALU result (same cycle or later)
//   o_send_data/valid,
//   i_send_ready              send-port handshake
//   o_busy                    state != IDLE
//   o_err                     sticky timeout flag, cleared only by reset
//   o_retired                 retired-instruction count (wraps)
module seq_ctrl #(
    parameter int ALU_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_inst,
    input  logic             i_inst_valid,
    output logic             o_inst_ready,
    output logic [ALU_W-1:0] o_alu_a,
    output logic [ALU_W-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    output logic [3:0]       o_alu_const,
    output logic             o_alu_valid,
    input  logic [ALU_W-1:0] i_alu_data,
    input  logic             i_alu_valid,
    output logic [ALU_W-1:0] o_send_data,
    output logic             o_send_valid,
    input  logic             i_send_ready,
    output logic             o_busy,
    output logic             o_err,
    output logic [7:0]       o_retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_SEND = 2'd3;

    state_t           state;
    logic [ALU_W-1:0] regs [4];
    logic [1:0]       ra_q;
    logic [1:0]       rd_q;
    logic [1:0]       dst;
    logic [7:0]       wait_cnt;

    assign o_inst_ready = (state == IDLE) && !rst;

    // push writes back to its ra field, add/mult to the rd field
    assign dst = (o_alu_op == OP_PUSH) ? ra_q : rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
            wait_cnt     <= '0;
            o_retired    <= '0;
            o_err        <= 1'b0;
            o_alu_valid  <= 1'b0;
            o_send_valid <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_inst_valid) begin
                        // Operands are captured at accept; the register file cannot
                        // change before the write-back that ends this instruction.
                        ra_q        <= i_inst[5:4];
                        rd_q        <= i_inst[1:0];
                        o_alu_op    <= i_inst[7:6];
                        o_alu_const <= i_inst[3:0];
                        o_alu_a     <= regs[i_inst[5:4]];
                        o_alu_b     <= regs[i_inst[3:2]];
                        o_send_data <= regs[i_inst[5:4]];
                        o_busy      <= 1'b1;
                        if (i_inst[7:6] == OP_SEND) begin
                            state        <= SEND;
                            o_send_valid <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            o_alu_valid <= 1'b1;
                        end
                    end
                end

                ISSUE, WAIT: begin
                    o_alu_valid <= 1'b0;
                    if (i_alu_valid) begin
                        regs[dst] <= i_alu_data;
                        o_retired <= o_retired + 8'd1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else if (state == ISSUE) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else if (wait_cnt == 8'(TIMEOUT)) begin
                        o_err  <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                SEND: begin
                    if (i_send_ready) begin
                        o_send_valid <= 1'b0;
                        o_retired    <= o_retired + 8'd1;
                        o_busy       <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl -- directed self-checking bench for seq_ctrl.
// Contains a behavioural ALU: push and add answer in the issue cycle, mult
// answers two cycles after issue (three cycles of stable operands).
module tb_seq_ctrl;

    localparam int ALU_W   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       i_inst;
    logic             i_inst_valid;
    logic             o_inst_ready;
    logic [ALU_W-1:0] o_alu_a;
    logic [ALU_W-1:0] o_alu_b;
    logic [1:0]       o_alu_op;
    logic [3:0]       o_alu_const;
    logic             o_alu_valid;
    logic [ALU_W-1:0] i_alu_data;
    logic             i_alu_valid;
    logic [ALU_W-1:0] o_send_data;
    logic             o_send_valid;
    logic             i_send_ready;
    logic             o_busy;
    logic             o_err;
    logic [7:0]       o_retired;

    seq_ctrl #(.ALU_W(ALU_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_inst       (i_inst),
        .i_inst_valid (i_inst_valid),
        .o_inst_ready (o_inst_ready),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_alu_const  (o_alu_const),
        .o_alu_valid  (o_alu_valid),
        .i_alu_data   (i_alu_data),
        .i_alu_valid  (i_alu_valid),
        .o_send_data  (o_send_data),
        .o_send_valid (o_send_valid),
        .i_send_ready (i_send_ready),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_retired    (o_retired)
    );

    always #5 clk = ~clk;

    // ---------------- ALU model ----------------
    logic alu_mute = 1'b0;
    int   mult_cnt = 0;

    always @(posedge clk) begin
        if (o_alu_valid && o_alu_op == 2'd2) mult_cnt <= 1;
        else if (mult_cnt == 1)              mult_cnt <= 2;
        else                                 mult_cnt <= 0;
    end

    logic [ALU_W-1:0] alu_sum, alu_prod;
    assign alu_sum  = o_alu_a + o_alu_b;
    assign alu_prod = o_alu_a * o_alu_b;
    assign i_alu_data  = (o_alu_op == 2'd0) ? ALU_W'(o_alu_const) :
                         (o_alu_op == 2'd1) ? alu_sum : alu_prod;
    assign i_alu_valid = !alu_mute &&
                         ((o_alu_valid && o_alu_op != 2'd2) || mult_cnt == 2);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one instruction, then follow it until the controller is ready again.
    // hold = number of cycles i_send_ready stays low while o_send_valid is up.
    task automatic run_inst(input logic [7:0] inst, input int hold,
                            output int lat, output int alu_pulses,
                            output int send_cycles, output logic stable,
                            output logic [7:0] sdata);
        logic [ALU_W-1:0] a0, b0;
        logic [1:0]       op0;
        logic [3:0]       c0;
        @(negedge clk);
        i_inst       = inst;
        i_inst_valid = 1'b1;
        i_send_ready = (hold == 0);
        check("accept_ready", 32'(o_inst_ready), 32'd1);
        @(negedge clk);
        i_inst_valid = 1'b0;
        lat = 1; alu_pulses = 0; send_cycles = 0; stable = 1'b1;
        a0 = o_alu_a; b0 = o_alu_b; op0 = o_alu_op; c0 = o_alu_const;
        sdata = o_send_data;
        check("latched_op", 32'(o_alu_op), 32'(inst[7:6]));
        while (!o_inst_ready && lat < 64) begin
            if (o_alu_valid) alu_pulses++;
            if (o_busy && o_alu_op != 2'd3)
                if (o_alu_a != a0 || o_alu_b != b0 || o_alu_op != op0 || o_alu_const != c0)
                    stable = 1'b0;
            if (o_send_valid) begin
                send_cycles++;
                if (o_send_data != sdata) stable = 1'b0;
                if (send_cycles > hold) i_send_ready = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        i_send_ready = 1'b0;
        check("idle_alu_valid", 32'(o_alu_valid), 32'd0);
        check("idle_send_valid", 32'(o_send_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses, scyc;
        logic stab;
        logic [7:0] sd;

        rst = 1'b1; i_inst = '0; i_inst_valid = 1'b0; i_send_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_inst_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_alu_valid", 32'(o_alu_valid), 32'd0);
        check("rst_send_valid", 32'(o_send_valid), 32'd0);
        check("rst_retired", 32'(o_retired), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(o_inst_ready), 32'd1);

        // push R1 = 5
        run_inst(8'h15, 0, lat, pulses, scyc, stab, sd);
        check("push_lat", 32'(lat), 32'd2);
        check("push_pulses", 32'(pulses), 32'd1);
        check("push_retired", 32'(o_retired), 32'd1);
        // push R2 = 3
        run_inst(8'h23, 0, lat, pulses, scyc, stab, sd);
        check("push2_retired", 32'(o_retired), 32'd2);
        // R3 = R1 + R2
        run_inst(8'h5B, 0, lat, pulses, scyc, stab, sd);
        check("add_lat", 32'(lat), 32'd2);
        check("add_pulses", 32'(pulses), 32'd1);
        // send R3
        run_inst(8'hF0, 0, lat, pulses, scyc, stab, sd);
        check("send_add_data", 32'(sd), 32'h08);
        check("send_cycles", 32'(scyc), 32'd1);
        check("send_lat", 32'(lat), 32'd2);
        check("send_retired", 32'(o_retired), 32'd4);

        // R3 = R1 * R2 with 3-cycle ALU
        run_inst(8'h9B, 0, lat, pulses, scyc, stab, sd);
        check("mult_lat", 32'(lat), 32'd4);
        check("mult_pulses", 32'(pulses), 32'd1);
        check("mult_stable", 32'(stab), 32'd1);
        check("mult_retired", 32'(o_retired), 32'd5);
        // send R3 with 4 cycles of backpressure
        run_inst(8'hF0, 4, lat, pulses, scyc, stab, sd);
        check("bp_data", 32'(sd), 32'h0F);
        check("bp_cycles", 32'(scyc), 32'd5);
        check("bp_stable", 32'(stab), 32'd1);
        check("bp_retired", 32'(o_retired), 32'd6);

        // R1 = R1 + R1 (read old, write new)
        run_inst(8'h55, 0, lat, pulses, scyc, stab, sd);
        run_inst(8'hD0, 0, lat, pulses, scyc, stab, sd);
        check("self_add_data", 32'(sd), 32'h0A);
        check("self_add_retired", 32'(o_retired), 32'd8);

        // timeout: ALU silent, R3 must keep 0x0F
        alu_mute = 1'b1;
        run_inst(8'h5B, 0, lat, pulses, scyc, stab, sd);
        alu_mute = 1'b0;
        check("to_lat", 32'(lat), 32'(TIMEOUT + 3));
        check("to_pulses", 32'(pulses), 32'd1);
        check("to_err", 32'(o_err), 32'd1);
        check("to_busy", 32'(o_busy), 32'd0);
        check("to_retired", 32'(o_retired), 32'd8);
        run_inst(8'hF0, 0, lat, pulses, scyc, stab, sd);
        check("to_r3_kept", 32'(sd), 32'h0F);
        check("to_err_sticky", 32'(o_err), 32'd1);
        check("to_send_retired", 32'(o_retired), 32'd9);

        // reset in the middle of a mult WAIT; late ALU valid must be ignored
        @(negedge clk);
        i_inst = 8'h9B; i_inst_valid = 1'b1;
        @(negedge clk);
        i_inst_valid = 1'b0;
        check("rw_issue", 32'(o_alu_valid), 32'd1);
        @(negedge clk);
        check("rw_wait_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rw_rst_ready", 32'(o_inst_ready), 32'd0);
        check("rw_rst_busy", 32'(o_busy), 32'd0);
        check("rw_rst_alu_valid", 32'(o_alu_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rw_busy", 32'(o_busy), 32'd0);
        check("rw_retired", 32'(o_retired), 32'd0);
        check("rw_err", 32'(o_err), 32'd0);
        check("rw_alu_valid", 32'(o_alu_valid), 32'd0);
        run_inst(8'hD0, 0, lat, pulses, scyc, stab, sd);
        check("rw_r1", 32'(sd), 32'h00);
        check("rw_retired1", 32'(o_retired), 32'd1);
        run_inst(8'hE0, 0, lat, pulses, scyc, stab, sd);
        check("rw_r2", 32'(sd), 32'h00);
        run_inst(8'hF0, 0, lat, pulses, scyc, stab, sd);
        check("rw_r3", 32'(sd), 32'h00);
        check("rw_retired3", 32'(o_retired), 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter: ALU_W, 8, ALU and register data width.
REQ-002 Parameter: TIMEOUT, 15, maximum WAIT cycles before abort (1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_inst  input  8  instruction: [7:6] op (0 push, 1 add, 2 mult, 3 send), [5:4] ra/rd, [3:2] rb, [1:0] rd, [3:0] const for push.
REQ-006 i_inst_valid  input  1  instruction offered.
REQ-007 o_inst_ready  output  1  controller accepts the instruction this cycle.
REQ-008 o_alu_a, o_alu_b  output  ALU_W each  ALU operands.
REQ-009 o_alu_op  output  2  ALU opcode; o_alu_const  output  4  push constant.
REQ-010 o_alu_valid  output  1  one-cycle issue strobe.
REQ-011 i_alu_data  input  ALU_W; i_alu_valid  input  1  ALU result and its valid, same-cycle or later.
REQ-012 o_send_data  output  ALU_W; o_send_valid  output  1; i_send_ready  input  1  send-port handshake.
REQ-013 o_busy  output  1  state != IDLE; o_err  output  1  sticky timeout flag; o_retired  output  8  retired-instruction count.

Function
REQ-014 The block SHALL hold a 4 x ALU_W register file R0..R3; all four are general purpose.
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and SEND.
REQ-016 o_inst_ready SHALL be 1 exactly when state==IDLE and rst==0.
REQ-017 IDLE: on i_inst_valid & o_inst_ready the block SHALL latch i_inst; op 3 -> SEND, otherwise -> ISSUE.
REQ-018 ISSUE SHALL hold o_alu_valid=1 for exactly one cycle.
REQ-019 ISSUE operands: push -> a=R[i[5:4]], const=i[3:0]; add/mult -> a=R[i[5:4]], b=R[i[3:2]].
REQ-020 o_alu_op SHALL equal the latched op.
REQ-021 Operands, op and const SHALL stay stable from ISSUE through the final WAIT cycle.
REQ-022 Write-back:
- In ISSUE or WAIT with i_alu_valid=1, write i_alu_data at that edge.
- Destination: push -> R[i[5:4]]; add/mult -> R[i[1:0]].
- Then increment o_retired (wraps 255->0) and go to IDLE.
REQ-023 ISSUE with i_alu_valid=0 SHALL go to WAIT and clear the wait counter.
REQ-024 WAIT SHALL increment the wait counter each cycle with i_alu_valid=0.
REQ-025 Timeout: counter==TIMEOUT with i_alu_valid=0 -> set o_err, no write-back, no retire, go to IDLE.
REQ-026 i_alu_valid SHALL be ignored in IDLE and SEND.
REQ-027 SEND SHALL drive o_send_data=R[i[5:4]] and o_send_valid=1 until i_send_ready=1.
REQ-028 SEND completion: at the edge with i_send_ready=1, increment o_retired and go to IDLE; o_send_valid is 0 the next cycle.
REQ-029 o_alu_valid=0 and o_send_valid=0 in every state other than ISSUE and SEND respectively.
REQ-030 Minimum instruction time: 2 cycles (accept, then ISSUE with same-cycle valid); the next accept is in the third cycle.
REQ-031 The same register as source and destination SHALL read the old value and write the new value.

Reset
REQ-032 With rst=1 at an edge, the block SHALL set:
- state=IDLE;
- R0..R3=0;
- wait counter=0, o_retired=0, o_err=0 (o_err is cleared only by reset);
- o_alu_valid=0, o_send_valid=0, o_busy=0.
REQ-033 While rst=1, o_inst_ready SHALL be 0.
REQ-034 rst mid-WAIT or mid-SEND SHALL abort with no write-back, no retire and no further strobes.

Verification
REQ-035 Bench ALU model: same-cycle push, 0-cycle add, 3-cycle mult, valid only on request.
- Push after reset: inst 0x15 -> R1=0x05, o_retired=1, o_inst_ready high again 2 cycles after accept.
- Add: R1=0x05, R2=0x03; inst 0x5B (R1+R2->R3), then send 0xF0 -> o_send_data=0x08.
- Mult with 3-cycle latency: operands stable 3 cycles, single o_alu_valid pulse, R3=0x0F after R1*R2.
REQ-036 Send backpressure: i_send_ready low 4 cycles -> o_send_valid held 5 cycles with constant data; exactly one retire.
REQ-037 Timeout: ALU never responds -> o_err=1 after TIMEOUT WAIT cycles, registers unchanged, IDLE, o_err stays 1 until rst.
REQ-038 Reset mid-WAIT: rst asserted during mult WAIT -> all registers 0, o_retired=0, late i_alu_valid ignored.
